// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: arbiter FSM states and default bus widths
// used by the arbiter and ctrl_async.
package wb_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

    localparam int WB_AW = 4;
    localparam int WB_DW = 8;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin pick: first set request after `last`, wrapping mod N.
module arb_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        // Walk from the farthest candidate to the nearest, so the last hit
        // (the one closest after `last`) is the one kept.
        for (int i = N; i >= 1; i--) begin
            cand = IW'((int'(last) + i) % N);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone B4 peripheral among N controllers,
// with a watchdog that errors out a transaction whose peripheral never acks.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int N       = 2,
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N-1:0]    ctrl_stb_i,
    input  logic [N-1:0]    ctrl_we_i,
    input  logic [N*AW-1:0] ctrl_adr_i,
    input  logic [N*DW-1:0] ctrl_dat_i,
    output logic [DW-1:0]   ctrl_dat_o,
    output logic [N-1:0]    ctrl_ack_o,
    output logic [N-1:0]    ctrl_err_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_stb_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i
);

    localparam int GW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT);

    arb_state_e    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pick_valid;
    logic [GW-1:0] pick_idx;

    logic [AW-1:0] adr_a [N];
    logic [DW-1:0] dat_a [N];

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign adr_a[k] = ctrl_adr_i[k*AW +: AW];
        assign dat_a[k] = ctrl_dat_i[k*DW +: DW];
    end

    arb_rr_pick #(.N(N)) u_pick (
        .req   (ctrl_stb_i),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= GW'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        ctrl_dat_o = '0;
        ctrl_ack_o = '0;
        ctrl_err_o = '0;
        wb_we_o    = 1'b0;
        wb_adr_o   = '0;
        wb_dat_o   = '0;
        wb_stb_o   = 1'b0;

        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                wb_we_o  = ctrl_we_i[grant_q];
                wb_adr_o = adr_a[grant_q];
                wb_dat_o = dat_a[grant_q];
                wb_stb_o = ctrl_stb_i[grant_q];
                // Ack beats timeout beats abort; the counter only advances
                // while the transaction stays open, so it never wraps.
                if (wb_ack_i) begin
                    ctrl_ack_o[grant_q] = 1'b1;
                    ctrl_dat_o          = wb_dat_i;
                    state_d             = StIdle;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    ctrl_err_o[grant_q] = 1'b1;
                    ctrl_dat_o          = '1;
                    state_d             = StIdle;
                end else if (!ctrl_stb_i[grant_q]) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected responses go to a scoreboard queue
// when a transaction starts and are compared when ack/err appears.
module tb_wb_arbiter;

    localparam int N  = 2;
    localparam int AW = 4;
    localparam int DW = 8;

    logic            clk_i;
    logic            rst_ni;
    logic [N-1:0]    ctrl_stb_i;
    logic [N-1:0]    ctrl_we_i;
    logic [N*AW-1:0] ctrl_adr_i;
    logic [N*DW-1:0] ctrl_dat_i;
    logic [DW-1:0]   ctrl_dat_o;
    logic [N-1:0]    ctrl_ack_o;
    logic [N-1:0]    ctrl_err_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic            wb_stb_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;

    typedef struct {
        logic [1:0] ack;
        logic [1:0] err;
        logic [7:0] dat;
        logic [3:0] adr;
        logic       we;
        logic [7:0] wdat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    wb_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ctrl_stb_i (ctrl_stb_i),
        .ctrl_we_i  (ctrl_we_i),
        .ctrl_adr_i (ctrl_adr_i),
        .ctrl_dat_i (ctrl_dat_i),
        .ctrl_dat_o (ctrl_dat_o),
        .ctrl_ack_o (ctrl_ack_o),
        .ctrl_err_o (ctrl_err_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_stb_o   (wb_stb_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(int k, logic we, logic [3:0] adr, logic [7:0] dat);
        ctrl_we_i[k]          = we;
        ctrl_adr_i[k*AW +: AW] = adr;
        ctrl_dat_i[k*DW +: DW] = dat;
    endtask

    task automatic push(logic [1:0] ack, logic [1:0] err, logic [7:0] dat,
                        logic [3:0] adr, logic we, logic [7:0] wdat);
        exp_t e;
        e.ack = ack; e.err = err; e.dat = dat;
        e.adr = adr; e.we = we; e.wdat = wdat;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
                    ctrl_ack_o, ctrl_err_o, ctrl_dat_o});
    endfunction

    // Response monitor: any ack/err must match the oldest expected entry.
    always @(negedge clk_i) begin
        check("onehot_resp", 32'($onehot0({ctrl_ack_o, ctrl_err_o})), 1);
        if (ctrl_ack_o != '0 || ctrl_err_o != '0) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 32'({ctrl_ack_o, ctrl_err_o}), 0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_ack",  32'(ctrl_ack_o), 32'(mon_e.ack));
                check("sb_err",  32'(ctrl_err_o), 32'(mon_e.err));
                check("sb_rdat", 32'(ctrl_dat_o), 32'(mon_e.dat));
                check("sb_adr",  32'(wb_adr_o),   32'(mon_e.adr));
                check("sb_we",   32'(wb_we_o),    32'(mon_e.we));
                check("sb_wdat", 32'(wb_dat_o),   32'(mon_e.wdat));
            end
        end
    end

    initial begin
        rst_ni     = 1'b0;
        ctrl_stb_i = '0;
        ctrl_we_i  = '0;
        ctrl_adr_i = '0;
        ctrl_dat_i = '0;
        wb_dat_i   = '0;
        wb_ack_i   = 1'b0;
        #2;
        check("reset_outs", all_outs(), 0);
        cyc();
        cyc();
        rst_ni = 1'b1;

        // ctrl0 write, peripheral acks on the third StBusy cycle.
        drive(0, 1'b1, 4'd3, 8'h5A);
        ctrl_stb_i[0] = 1'b1;
        push(2'b01, 2'b00, 8'h77, 4'd3, 1'b1, 8'h5A);
        #1 check("wr_idle_stb", 32'(wb_stb_o), 0);
        cyc();
        check("wr_stb", 32'(wb_stb_o), 1);
        check("wr_adr", 32'(wb_adr_o), 3);
        check("wr_dat", 32'(wb_dat_o), 32'h5A);
        check("wr_we",  32'(wb_we_o), 1);
        cyc();
        check("wr_noack", 32'(ctrl_ack_o), 0);
        cyc();
        wb_ack_i = 1'b1;
        wb_dat_i = 8'h77;
        #1 check("wr_ack", 32'(ctrl_ack_o), 32'b01);
        cyc();
        wb_ack_i      = 1'b0;
        ctrl_stb_i[0] = 1'b0;
        #1 check("wr_done_stb", 32'(wb_stb_o), 0);

        // ctrl1 read that never acks; ctrl0 fields wiggle meanwhile.
        cyc();
        drive(1, 1'b0, 4'd9, 8'hC3);
        ctrl_stb_i[1] = 1'b1;
        push(2'b00, 2'b10, 8'hFF, 4'd9, 1'b0, 8'hC3);
        for (int i = 1; i <= 16; i++) begin
            cyc();
            if (i == 5) drive(0, 1'b1, 4'd2, 8'hEE);
            #1;
            check("to_stb", 32'(wb_stb_o), 1);
            check("to_adr_hold", 32'(wb_adr_o), 9);
            if (i < 16) begin
                check("to_early_err", 32'(ctrl_err_o), 0);
            end else begin
                check("to_err", 32'(ctrl_err_o), 32'b10);
                check("to_dat", 32'(ctrl_dat_o), 32'hFF);
            end
        end
        cyc();
        ctrl_stb_i[1] = 1'b0;
        #1 check("to_after_stb", 32'(wb_stb_o), 0);

        // Both controllers strobe continuously; ack in the second StBusy cycle.
        drive(0, 1'b0, 4'd1, 8'h11);
        drive(1, 1'b1, 4'd2, 8'h22);
        ctrl_stb_i = 2'b11;
        #1 check("rr_idle_stb", 32'(wb_stb_o), 0);
        for (int t = 0; t < 4; t++) begin
            if (t % 2 == 0) push(2'b01, 2'b00, 8'hA0 + 8'(t), 4'd1, 1'b0, 8'h11);
            else            push(2'b10, 2'b00, 8'hA0 + 8'(t), 4'd2, 1'b1, 8'h22);
            cyc();
            check("rr_stb", 32'(wb_stb_o), 1);
            check("rr_grant_adr", 32'(wb_adr_o), (t % 2 == 0) ? 1 : 2);
            cyc();
            wb_ack_i = 1'b1;
            wb_dat_i = 8'hA0 + 8'(t);
            #1 check("rr_ack", 32'(ctrl_ack_o), (t % 2 == 0) ? 1 : 2);
            cyc();
            wb_ack_i = 1'b0;
            if (t == 3) ctrl_stb_i = 2'b00;
            #1 check("rr_bubble", 32'(wb_stb_o), 0);
        end

        // Ack arriving on the 16th StBusy cycle wins over the timeout.
        drive(0, 1'b0, 4'd6, 8'h44);
        ctrl_stb_i[0] = 1'b1;
        push(2'b01, 2'b00, 8'h3C, 4'd6, 1'b0, 8'h44);
        for (int i = 1; i <= 16; i++) begin
            cyc();
            if (i == 16) begin
                wb_ack_i = 1'b1;
                wb_dat_i = 8'h3C;
            end
            #1;
            if (i == 16) begin
                check("late_ack", 32'(ctrl_ack_o), 32'b01);
                check("late_noerr", 32'(ctrl_err_o), 0);
                check("late_dat", 32'(ctrl_dat_o), 32'h3C);
            end
        end
        cyc();
        wb_ack_i      = 1'b0;
        ctrl_stb_i[0] = 1'b0;

        // ctrl1 aborts mid-transaction; a stray ack afterwards is ignored.
        drive(1, 1'b1, 4'd5, 8'h55);
        ctrl_stb_i[1] = 1'b1;
        cyc();
        check("ab_stb", 32'(wb_stb_o), 1);
        cyc();
        ctrl_stb_i[1] = 1'b0;
        #1 check("ab_stb_fall", 32'(wb_stb_o), 0);
        check("ab_noresp", 32'({ctrl_ack_o, ctrl_err_o}), 0);
        cyc();
        wb_ack_i = 1'b1;
        #1 check("ab_stray_ack", 32'(ctrl_ack_o), 0);
        cyc();
        wb_ack_i = 1'b0;
        check("ab_idle_stb", 32'(wb_stb_o), 0);

        // Async reset in the middle of a ctrl0 transaction.
        drive(0, 1'b1, 4'd7, 8'h71);
        drive(1, 1'b0, 4'd8, 8'h81);
        ctrl_stb_i[0] = 1'b1;
        cyc();
        check("rst_pre_stb", 32'(wb_stb_o), 1);
        #1 rst_ni = 1'b0;
        #1 check("rst_async_outs", all_outs(), 0);
        ctrl_stb_i = 2'b11;
        cyc();
        check("rst_held_outs", all_outs(), 0);
        rst_ni = 1'b1;
        push(2'b01, 2'b00, 8'h5D, 4'd7, 1'b1, 8'h71);
        cyc();
        check("rst_first_grant", 32'(wb_adr_o), 7);
        cyc();
        wb_ack_i = 1'b1;
        wb_dat_i = 8'h5D;
        #1 check("rst_ack0", 32'(ctrl_ack_o), 32'b01);
        cyc();
        wb_ack_i      = 1'b0;
        ctrl_stb_i[0] = 1'b0;
        push(2'b10, 2'b00, 8'h6E, 4'd8, 1'b0, 8'h81);
        #1 check("rst_bubble", 32'(wb_stb_o), 0);
        cyc();
        check("rst_second_grant", 32'(wb_adr_o), 8);
        wb_ack_i = 1'b1;
        wb_dat_i = 8'h6E;
        #1 check("rst_ack1", 32'(ctrl_ack_o), 32'b10);
        cyc();
        wb_ack_i   = 1'b0;
        ctrl_stb_i = 2'b00;
        cyc();
        cyc();

        check("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
